// File: rtl/match_controller.sv
// Two-player tug-of-war match sequencer: countdown, live play, point hold and game-over,
// with saturating scores and a registered winner flag.
module match_controller #(
  parameter int WIN_SCORE   = 7,
  parameter int COUNT_START = 3,
  parameter int HOLD_TICKS  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       L,
  input  logic       R,
  input  logic       leftest,
  input  logic       rightest,
  output logic       resetField,
  output logic       play_en,
  output logic [2:0] scoreH,
  output logic [2:0] scoreC,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    COUNTDOWN = 3'b001,
    PLAY      = 3'b010,
    POINT     = 3'b011,
    OVER      = 3'b100
  } state_e;

  localparam logic [2:0] WIN   = 3'(WIN_SCORE);
  localparam logic [2:0] CSTRT = 3'(COUNT_START);
  localparam logic [2:0] HOLD  = 3'(HOLD_TICKS);

  state_e     state_q, state_d;
  logic [2:0] score_h_q, score_h_d;
  logic [2:0] score_c_q, score_c_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] winner_q, winner_d;

  logic award_h, award_c;

  // A simultaneous press or an illegal field (both ends lit) awards nothing.
  assign award_h = leftest & ~rightest & L & ~R;
  assign award_c = rightest & ~leftest & R & ~L;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      score_h_q <= '0;
      score_c_q <= '0;
      cnt_q     <= '0;
      winner_q  <= '0;
    end else begin
      state_q   <= state_d;
      score_h_q <= score_h_d;
      score_c_q <= score_c_d;
      cnt_q     <= cnt_d;
      winner_q  <= winner_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    score_h_d = score_h_q;
    score_c_d = score_c_q;
    cnt_d     = cnt_q;
    winner_d  = winner_q;
    unique case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d   = COUNTDOWN;
          cnt_d     = CSTRT;
          score_h_d = '0;
          score_c_d = '0;
          winner_d  = 2'b00;
        end
      end
      COUNTDOWN: begin
        if (tick) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = PLAY;
        end
      end
      PLAY: begin
        if (award_h) begin
          if (score_h_q < WIN) score_h_d = score_h_q + 3'd1;
          state_d = POINT;
          cnt_d   = HOLD;
        end else if (award_c) begin
          if (score_c_q < WIN) score_c_d = score_c_q + 3'd1;
          state_d = POINT;
          cnt_d   = HOLD;
        end
      end
      POINT: begin
        if (tick) begin
          if (cnt_q == 3'd1) begin
            if (score_h_q == WIN || score_c_q == WIN) begin
              state_d  = OVER;
              cnt_d    = '0;
              winner_d = (score_h_q == WIN) ? 2'b01 : 2'b10;
            end else begin
              state_d = COUNTDOWN;
              cnt_d   = CSTRT;
            end
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    play_en    = (state_q == PLAY);
    resetField = (state_q != PLAY);
    state      = state_q;
    scoreH     = score_h_q;
    scoreC     = score_c_q;
    winner     = winner_q;
  end

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller at default parameters (WIN 7, countdown 3, hold 2).
module tb_match_controller;

  logic       clk = 1'b0;
  logic       reset, tick, start, L, R, leftest, rightest;
  logic       resetField, play_en;
  logic [2:0] scoreH, scoreC, state;
  logic [1:0] winner;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  match_controller #(.WIN_SCORE(7), .COUNT_START(3), .HOLD_TICKS(2)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .L(L), .R(R),
    .leftest(leftest), .rightest(rightest), .resetField(resetField),
    .play_en(play_en), .scoreH(scoreH), .scoreC(scoreC), .winner(winner),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1ns after the edge with pulses cleared.
  task automatic step(input logic t, input logic s, input logic l, input logic r,
                      input logic le, input logic ri);
    tick = t; start = s; L = l; R = r; leftest = le; rightest = ri;
    @(posedge clk);
    #1;
    tick = 0; start = 0; L = 0; R = 0; leftest = 0; rightest = 0;
  endtask

  task automatic countdown();
    step(1, 0, 0, 0, 0, 0); check("cd_t1", 8'(state), 8'h1);
    step(1, 0, 0, 0, 0, 0); check("cd_t2", 8'(state), 8'h1);
    step(1, 0, 0, 0, 0, 0); check("cd_t3", 8'(state), 8'h2);
  endtask

  initial begin
    reset = 0; tick = 0; start = 0; L = 0; R = 0; leftest = 0; rightest = 0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0);
    check("rst_state", 8'(state), 8'h0);
    check("rst_scoreH", 8'(scoreH), 8'h0);
    check("rst_scoreC", 8'(scoreC), 8'h0);
    check("rst_winner", 8'(winner), 8'h0);
    check("rst_resetField", 8'(resetField), 8'h1);
    check("rst_play_en", 8'(play_en), 8'h0);

    reset = 1;
    step(1, 0, 1, 0, 1, 0); check("idle_ignore", 8'(state), 8'h0);
    step(0, 1, 0, 0, 0, 0); check("start_cd", 8'(state), 8'h1);
    step(0, 0, 1, 0, 1, 0); check("cd_L_scoreH", 8'(scoreH), 8'h0);
    step(0, 0, 0, 1, 0, 1); check("cd_R_scoreC", 8'(scoreC), 8'h0);
    step(0, 0, 0, 0, 0, 0); check("cd_notick", 8'(state), 8'h1);
    countdown();
    check("play_en", 8'(play_en), 8'h1);
    check("play_resetField", 8'(resetField), 8'h0);

    step(0, 0, 1, 1, 1, 0);
    check("both_press_state", 8'(state), 8'h2);
    check("both_press_scoreH", 8'(scoreH), 8'h0);
    step(0, 0, 1, 0, 1, 1);
    check("illegal_field_state", 8'(state), 8'h2);
    check("illegal_field_scoreH", 8'(scoreH), 8'h0);
    step(0, 1, 0, 0, 0, 0); check("play_start_ignored", 8'(state), 8'h2);
    step(0, 0, 1, 0, 0, 0); check("L_not_leftest", 8'(state), 8'h2);

    step(1, 0, 1, 0, 1, 0);
    check("human_pt_scoreH", 8'(scoreH), 8'h1);
    check("human_pt_state", 8'(state), 8'h3);
    step(0, 1, 0, 0, 0, 0); check("point_start_ignored", 8'(state), 8'h3);
    step(1, 0, 0, 0, 0, 0); check("hold_t1", 8'(state), 8'h3);
    step(1, 0, 0, 0, 0, 0); check("hold_t2", 8'(state), 8'h1);

    for (int i = 0; i < 7; i++) begin
      countdown();
      step(0, 0, 0, 1, 0, 1);
      check("cyber_pt_scoreC", 8'(scoreC), 8'(i + 1));
      check("cyber_pt_state", 8'(state), 8'h3);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      check("after_hold", 8'(state), (i == 6) ? 8'h4 : 8'h1);
    end
    check("over_winner", 8'(winner), 8'h2);
    check("over_scoreH", 8'(scoreH), 8'h1);
    step(1, 0, 0, 1, 0, 1);
    check("over_R_scoreC", 8'(scoreC), 8'h7);
    check("over_R_state", 8'(state), 8'h4);
    check("over_winner_hold", 8'(winner), 8'h2);
    check("over_resetField", 8'(resetField), 8'h1);

    step(0, 1, 0, 0, 0, 0);
    check("restart_state", 8'(state), 8'h1);
    check("restart_scoreH", 8'(scoreH), 8'h0);
    check("restart_scoreC", 8'(scoreC), 8'h0);
    check("restart_winner", 8'(winner), 8'h0);

    for (int i = 0; i < 5; i++) begin
      countdown();
      step(0, 0, 1, 0, 1, 0);
      check("human_run_scoreH", 8'(scoreH), 8'(i + 1));
      if (i < 4) begin
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
      end
    end
    check("pre_reset_state", 8'(state), 8'h3);
    reset = 0;
    step(1, 1, 0, 0, 0, 0);
    check("midmatch_rst_state", 8'(state), 8'h0);
    check("midmatch_rst_scoreH", 8'(scoreH), 8'h0);
    check("midmatch_rst_scoreC", 8'(scoreC), 8'h0);
    check("midmatch_rst_resetField", 8'(resetField), 8'h1);
    check("midmatch_rst_play_en", 8'(play_en), 8'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
